// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
);

  localparam int unsigned CntW = ptr_width(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CntW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count,
    output overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port, one registered read port, no reset.
module fifo_mem_dp
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Same-address write and read in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with wrap-bit pointers, registered read and status flags.
// Optional sticky overflow/underflow detection is built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_param_if.slave     bus
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] AfLevel = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AeLevel = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_valid_q;
  logic             loaded_q;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  always_comb begin
    full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
            (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    empty = (wr_ptr_q == rd_ptr_q);
    count = wr_ptr_q - rd_ptr_q;
  end

  // A write into a full FIFO only lands when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc = bus.rd_en && !empty && !bus.flush;
    wr_acc = bus.wr_en && !bus.flush && (!full || rd_acc);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_acc;
      loaded_q   <= loaded_q | rd_acc;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // The storage read register has no reset; mask it until the first accepted read.
  assign bus.data_out     = loaded_q ? mem_rdata : '0;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AfLevel);
  assign bus.almost_empty = (count <= AeLevel);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full && !rd_acc) overflow_q  <= 1'b1;
      if (bus.rd_en && empty)           underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed corner cases plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int unsigned Depth = DefDepth;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_param_if bus ();

  sync_fifo_param u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_dout;
  bit         exp_valid;
  bit         exp_ovf;
  bit         exp_udf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic check_all();
    int unsigned n;
    n = model_q.size();
    check_eq("count",        32'(bus.count),        32'(n));
    check_eq("empty",        32'(bus.empty),        32'(n == 0));
    check_eq("full",         32'(bus.full),         32'(n == Depth));
    check_eq("almost_full",  32'(bus.almost_full),  32'(n >= Depth - 2));
    check_eq("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    check_eq("data_out",     32'(bus.data_out),     32'(exp_dout));
    check_eq("rd_valid",     32'(bus.rd_valid),     32'(exp_valid));
    check_eq("overflow",     32'(bus.overflow),     32'(exp_ovf));
    check_eq("underflow",    32'(bus.underflow),    32'(exp_udf));
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, check on the falling edge.
  task automatic step(input bit fl, input bit wr, input bit rd, input logic [7:0] din);
    bit ra;
    bit wa;
    bus.flush   = fl;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    @(posedge clk);
    ra = rd && (model_q.size() != 0) && !fl;
    wa = wr && !fl && ((model_q.size() < Depth) || ra);
    if (ErrEn) begin
      if (fl) begin
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
      end else begin
        if (wr && (model_q.size() == Depth) && !ra) exp_ovf = 1'b1;
        if (rd && (model_q.size() == 0))            exp_udf = 1'b1;
      end
    end
    if (fl) begin
      model_q.delete();
    end else begin
      if (ra) exp_dout = model_q.pop_front();
      if (wa) model_q.push_back(din);
    end
    exp_valid = ra;
    @(negedge clk);
    check_all();
  endtask

  task automatic random_phase(input int unsigned cycles, input int unsigned pw,
                              input int unsigned pr);
    for (int c = 0; c < cycles; c++) begin
      bit         wr;
      bit         rd;
      bit         fl;
      logic [7:0] d;
      wr = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      fl = ($urandom_range(0, 199) == 0);
      d  = 8'($urandom);
      step(fl, wr, rd, d);
      check_eq("count_bound", 32'(bus.count <= 5'(Depth)), 32'd1);
    end
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    rst = 1'b0;
    model_reset();

    // Reset then idle
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    @(negedge clk);
    check_all();

    // Fill with 0x01..0x10, watch almost_full come up at 14
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i + 1));
      if (i == 12) check_eq("af_at_13", 32'(bus.almost_full), 32'd0);
      if (i == 13) check_eq("af_at_14", 32'(bus.almost_full), 32'd1);
    end
    check_eq("fill_full",  32'(bus.full),  32'd1);
    check_eq("fill_count", 32'(bus.count), 32'd16);

    // Drain in order, one cycle latency
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check_eq("drain_data",  32'(bus.data_out), 32'(i + 1));
      check_eq("drain_valid", 32'(bus.rd_valid), 32'd1);
    end
    check_eq("drain_empty", 32'(bus.empty), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("hold_data", 32'(bus.data_out), 32'h10);

    // Read while empty; write+read into empty is not a bypass
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("udf_set", 32'(bus.underflow), 32'(ErrEn));
    step(1'b0, 1'b1, 1'b1, 8'h77);
    check_eq("empty_wr_rd_valid", 32'(bus.rd_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("empty_wr_rd_data", 32'(bus.data_out), 32'h77);

    // Refill, overflow attempt, then simultaneous write+read while full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    check_eq("ovf_set", 32'(bus.overflow), 32'(ErrEn));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("ovf_sticky", 32'(bus.overflow), 32'(ErrEn));
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    check_eq("full_wr_rd_count", 32'(bus.count),    32'd16);
    check_eq("full_wr_rd_data",  32'(bus.data_out), 32'h20);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("aa_last", 32'(bus.data_out), 32'hAA);

    // Flush clears error flags, and overrides a concurrent write
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("flush_ovf", 32'(bus.overflow),  32'd0);
    check_eq("flush_udf", 32'(bus.underflow), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    step(1'b1, 1'b1, 1'b0, 8'h99);
    check_eq("flush_count", 32'(bus.count), 32'd0);
    check_eq("flush_empty", 32'(bus.empty), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("flush_rd_rejected", 32'(bus.rd_valid), 32'd0);

    // Random traffic: write-biased, read-biased, balanced (crosses pointer wrap many times)
    random_phase(400, 80, 30);
    random_phase(400, 30, 80);
    random_phase(800, 60, 60);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, (i > 2), 8'(8'h60 + i));
    bus.wr_en = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    bus.wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("post_reset_first", 32'(bus.data_out), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
